// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, receiver FSM states, byte type.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 10;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO between the UART receiver and downstream command logic.
// Latency: a push is visible on pop_dat/empty the cycle after the push cycle.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and pulses overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     inclk,
    input  logic                     reset,
    input  logic                     push,
    input  byte_t                    push_dat,
    input  logic                     pop,
    output byte_t                    pop_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
    assign push_ok  = push && (!full || pop_ok);
    assign overflow = push && full && !pop_ok;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/my_uart_rx.sv
// 8N1 UART receiver with majority-vote bit sampling, framing/overrun flags and a byte FIFO.
// Latency: byte pushed one cycle after the stop-bit vote; fifo_empty falls the cycle after that.
// Backpressure: none on the line; bytes arriving while the FIFO is full are dropped and set overrun.
module my_uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          inclk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clear_errors,
    output logic [7:0]                    rd_data,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_error,
    output logic                          overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    rx_state_t              state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       cnt_wrap;
    logic [2:0]             bit_idx;
    logic [1:0]             samp_q;
    logic                   vote;
    byte_t                  shift_q;
    logic                   push_vld;
    logic                   fifo_full;
    logic                   fifo_ovf;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign vote     = maj3(samp_q[1], samp_q[0], rx_s);
    assign cnt_wrap = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            samp_q        <= '1;
            shift_q       <= '0;
            push_vld      <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            if (clear_errors) begin
                framing_error <= 1'b0;
            end
            if (bit_cnt == CNT_MID_M1) begin
                samp_q[1] <= rx_s;
            end
            if (bit_cnt == CNT_MID) begin
                samp_q[0] <= rx_s;
            end
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_cnt == CNT_MID_P1) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= vote ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    bit_cnt <= cnt_wrap;
                    if (bit_cnt == CNT_MID_P1) begin
                        shift_q <= {vote, shift_q[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    bit_cnt <= cnt_wrap;
                    if (bit_cnt == CNT_MID_P1) begin
                        if (vote) begin
                            push_vld <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Placed after the clear so a same-cycle error leaves the flag set.
                            framing_error <= 1'b1;
                            bit_cnt       <= '0;
                            state         <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (!rx_s) begin
                        bit_cnt <= '0;
                    end else if (bit_cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (fifo_ovf) begin
            overrun <= 1'b1;
        end else if (clear_errors) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .inclk    (inclk),
        .reset    (reset),
        .push     (push_vld),
        .push_dat (shift_q),
        .pop      (rd_en),
        .pop_dat  (rd_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    ovf_implies_full: assert property (@(posedge inclk) disable iff (reset) fifo_ovf |-> fifo_full);

endmodule

// File: tb/tb_my_uart_rx.sv
// Directed bench for my_uart_rx: serial frames in, scoreboard of expected bytes out.
module tb_my_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 10;

    logic       inclk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       clear_errors;
    logic [7:0] rd_data;
    logic       fifo_empty;
    logic [2:0] fifo_count;
    logic       framing_error;
    logic       overrun;

    int    nvec = 0;
    int    nerr = 0;
    byte_t exp_q[$];

    my_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .SYNC_STAGES  (2)
    ) dut (
        .inclk         (inclk),
        .reset         (reset),
        .rx            (rx),
        .rd_en         (rd_en),
        .clear_errors  (clear_errors),
        .rd_data       (rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #25 inclk = ~inclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Each call starts just after a rising edge and returns just after one.
    task automatic send_bits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge inclk);
            #1;
        end
    endtask

    task automatic send_frame(input byte_t b, input logic stop);
        send_bits({stop, b, 1'b0}, 10);
    endtask

    task automatic send_good(input byte_t b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic pop_check(input string tag);
        byte_t exp_b;
        @(negedge inclk);
        chk({tag, "_nonempty"}, fifo_empty, 0);
        if (exp_q.size() != 0) exp_b = exp_q.pop_front();
        else exp_b = 8'hxx;
        chk({tag, "_data"}, rd_data, exp_b);
        rd_en = 1'b1;
        @(posedge inclk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge inclk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        idle(1);
        clear_errors = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        rx           = 1'b1;
        rd_en        = 1'b0;
        clear_errors = 1'b0;
        idle(3);
        @(negedge inclk);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        idle(5);

        // Single byte with push timing: push cycle is 97 edges after the start bit is driven.
        fork
            send_good(8'hA5);
            begin
                repeat (97) @(posedge inclk);
                @(negedge inclk) chk("a5_empty_push_cycle", fifo_empty, 1);
                @(negedge inclk) chk("a5_empty_after_push", fifo_empty, 0);
            end
        join
        @(negedge inclk);
        chk("a5_count", fifo_count, 1);
        chk("a5_ferr", framing_error, 0);
        chk("a5_ovr", overrun, 0);
        idle(1);
        pop_check("a5");

        // Back-to-back frames with a single stop bit.
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h55);
        idle(5);
        @(negedge inclk) chk("b2b_count", fifo_count, 3);
        idle(1);
        pop_check("b2b0");
        pop_check("b2b1");
        pop_check("b2b2");
        @(negedge inclk) chk("b2b_empty", fifo_empty, 1);
        idle(1);

        // Short low glitch on an idle line.
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        @(negedge inclk);
        chk("glitch_empty", fifo_empty, 1);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_ferr", framing_error, 0);
        idle(1);

        // Low stop bit followed by a held-low line, then recovery.
        send_frame(8'h3C, 1'b0);
        idle(30);
        rx = 1'b1;
        idle(20);
        @(negedge inclk);
        chk("frm_ferr", framing_error, 1);
        chk("frm_empty", fifo_empty, 1);
        idle(1);
        send_good(8'h81);
        idle(3);
        pop_check("frm_next");
        @(negedge inclk) chk("frm_ferr_sticky", framing_error, 1);
        idle(1);
        pulse_clear();
        @(negedge inclk) chk("frm_ferr_cleared", framing_error, 0);
        idle(1);

        // Overflow: fifth byte dropped.
        send_good(8'h11);
        send_good(8'h22);
        send_good(8'h33);
        send_good(8'h44);
        send_frame(8'h55, 1'b1);
        idle(3);
        @(negedge inclk);
        chk("ovr_count", fifo_count, 4);
        chk("ovr_flag", overrun, 1);
        idle(1);
        pop_check("ovr0");
        pop_check("ovr1");
        pop_check("ovr2");
        pop_check("ovr3");
        @(negedge inclk) chk("ovr_drained", fifo_empty, 1);
        idle(1);
        pulse_clear();
        @(negedge inclk) chk("ovr_cleared", overrun, 0);
        idle(1);

        // Same burst with a pop in the fifth byte's push cycle.
        send_good(8'h66);
        send_good(8'h77);
        send_good(8'h88);
        send_good(8'h99);
        fork
            send_good(8'hAA);
            begin
                repeat (97) @(posedge inclk);
                #1;
                rd_en = 1'b1;
                @(negedge inclk) chk("sim_head", rd_data, exp_q.pop_front());
                @(posedge inclk);
                #1;
                rd_en = 1'b0;
            end
        join
        idle(3);
        @(negedge inclk);
        chk("sim_count", fifo_count, 4);
        chk("sim_ovr", overrun, 0);
        idle(1);
        pop_check("sim0");
        pop_check("sim1");
        pop_check("sim2");
        pop_check("sim3");

        // Reset in the middle of a frame, with a byte already queued.
        send_frame(8'hC3, 1'b1);
        idle(3);
        @(negedge inclk) chk("pre_rst_count", fifo_count, 1);
        idle(1);
        send_bits({1'b1, 8'h7E, 1'b0}, 5);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge inclk);
        chk("mid_rst_rd_data", rd_data, 8'h00);
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ferr", framing_error, 0);
        chk("mid_rst_ovr", overrun, 0);
        idle(1);
        reset = 1'b0;
        idle(20);
        send_good(8'h12);
        for (int i = 0; i < 4 * CPB; i++) begin
            @(negedge inclk);
            if (!fifo_empty) break;
        end
        chk("post_rst_arrived", fifo_empty, 0);
        idle(1);
        pop_check("post_rst");
        @(negedge inclk);
        chk("post_rst_count", fifo_count, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #(50 * 20000);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
